// File: rtl/pipelined_control_unit.sv
// Registered RV32IM decode stage (ID/EX control register) with stall/flush and multi-cycle M-op hold.
// Optional M-extension decode and busy counter enabled by defining RV32M_EN.
module pipelined_control_unit #(
  parameter int MULDIV_LATENCY = 4,
  parameter int ALU_OP_W       = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                instr_valid,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                stall,
  input  logic                flush,
  output logic                ready,
  output logic                valid_out,
  output logic                write_en,
  output logic                mem_write,
  output logic                mem_read,
  output logic                branch,
  output logic                jump,
  output logic                pc_select,
  output logic                imm_select,
  output logic                jal_select,
  output logic                data_mem_select,
  output logic [2:0]          imm_pick,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                muldiv,
  output logic                illegal,
  output logic                muldiv_busy
);

  typedef struct packed {
    logic                write_en;
    logic                mem_write;
    logic                mem_read;
    logic                branch;
    logic                jump;
    logic                pc_select;
    logic                imm_select;
    logic                jal_select;
    logic                data_mem_select;
    logic [2:0]          imm_pick;
    logic [ALU_OP_W-1:0] alu_op;
    logic                muldiv;
    logic                illegal;
  } ctrl_t;

  if (MULDIV_LATENCY < 1 || MULDIV_LATENCY > 32 || ALU_OP_W < 3) begin : g_param_check
    $error("pipelined_control_unit: parameter out of range");
  end

  ctrl_t dec_s;
  ctrl_t bundle_r;
  logic  legal_s;
  logic  valid_r;
  logic  busy_s;
  logic  capture_s;

  // Instruction decode into the execute control bundle
  always_comb begin
    dec_s   = '0;
    legal_s = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (func7 == 7'b0000000 ||
            (func7 == 7'b0100000 && (func3 == 3'b000 || func3 == 3'b101))) begin
          legal_s        = 1'b1;
          dec_s.write_en = 1'b1;
`ifdef RV32M_EN
        end else if (func7 == 7'b0000001) begin
          legal_s        = 1'b1;
          dec_s.write_en = 1'b1;
          dec_s.muldiv   = 1'b1;
          dec_s.alu_op   = ALU_OP_W'(3'b100);
`endif
        end else begin
          legal_s = 1'b0;
        end
      end
      7'b0000011: begin
        legal_s               = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec_s.imm_select      = 1'b1;
        dec_s.write_en        = 1'b1;
        dec_s.mem_read        = 1'b1;
        dec_s.data_mem_select = 1'b1;
        dec_s.alu_op          = ALU_OP_W'(3'b001);
      end
      7'b1100111: begin
        legal_s          = (func3 == 3'b000);
        dec_s.write_en   = 1'b1;
        dec_s.jal_select = 1'b1;
        dec_s.imm_select = 1'b1;
        dec_s.jump       = 1'b1;
        dec_s.alu_op     = ALU_OP_W'(3'b010);
      end
      7'b0010011: begin
        legal_s = (func3 inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111}) ||
                  (func3 == 3'b001 && func7 == 7'b0000000) ||
                  (func3 == 3'b101 && (func7 == 7'b0000000 || func7 == 7'b0100000));
        dec_s.write_en   = 1'b1;
        dec_s.imm_select = 1'b1;
        dec_s.alu_op     = ALU_OP_W'(3'b011);
      end
      7'b0100011: begin
        legal_s          = func3 inside {3'b000, 3'b001, 3'b010};
        dec_s.mem_write  = 1'b1;
        dec_s.imm_select = 1'b1;
        dec_s.imm_pick   = 3'b001;
      end
      7'b0110111, 7'b0010111: begin
        legal_s          = 1'b1;
        dec_s.write_en   = 1'b1;
        dec_s.imm_select = 1'b1;
        dec_s.imm_pick   = 3'b010;
        dec_s.pc_select  = opcode[5] ? 1'b0 : 1'b1;
      end
      7'b1100011: begin
        legal_s          = !(func3 inside {3'b010, 3'b011});
        dec_s.branch     = 1'b1;
        dec_s.pc_select  = 1'b1;
        dec_s.imm_select = 1'b1;
        dec_s.imm_pick   = 3'b011;
      end
      7'b1101111: begin
        legal_s          = 1'b1;
        dec_s.jump       = 1'b1;
        dec_s.jal_select = 1'b1;
        dec_s.pc_select  = 1'b1;
        dec_s.imm_select = 1'b1;
        dec_s.write_en   = 1'b1;
        dec_s.imm_pick   = 3'b100;
      end
      default: legal_s = 1'b0;
    endcase
    // Failed decode collapses every control to 0 and flags the op
    if (!legal_s) begin
      dec_s         = '0;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.illegal = 1'b0;
    end
  end

`ifdef RV32M_EN
  localparam int CNT_W = $clog2(MULDIV_LATENCY + 1);
  logic [CNT_W-1:0] cnt_r;

  assign busy_s = (cnt_r != '0);

  // M-op busy counter; counts down even while stalled, flush aborts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (flush) begin
      cnt_r <= '0;
    end else if (busy_s) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else if (capture_s && dec_s.muldiv) begin
      cnt_r <= CNT_W'(MULDIV_LATENCY - 1);
    end else begin
      cnt_r <= '0;
    end
  end
`else
  assign busy_s = 1'b0;
`endif

  assign ready       = ~busy_s;
  assign muldiv_busy = busy_s;
  assign capture_s   = instr_valid & ready & ~stall & ~flush;

  // ID/EX control register: flush > hold > capture > bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bundle_r <= '0;
      valid_r  <= 1'b0;
    end else if (flush) begin
      bundle_r <= '0;
      valid_r  <= 1'b0;
    end else if (stall || busy_s) begin
      bundle_r <= bundle_r;
      valid_r  <= valid_r;
    end else if (capture_s) begin
      bundle_r <= dec_s;
      valid_r  <= 1'b1;
    end else begin
      bundle_r <= '0;
      valid_r  <= 1'b0;
    end
  end

  assign valid_out       = valid_r;
  assign write_en        = bundle_r.write_en;
  assign mem_write       = bundle_r.mem_write;
  assign mem_read        = bundle_r.mem_read;
  assign branch          = bundle_r.branch;
  assign jump            = bundle_r.jump;
  assign pc_select       = bundle_r.pc_select;
  assign imm_select      = bundle_r.imm_select;
  assign jal_select      = bundle_r.jal_select;
  assign data_mem_select = bundle_r.data_mem_select;
  assign imm_pick        = bundle_r.imm_pick;
  assign alu_op          = bundle_r.alu_op;
  assign muldiv          = bundle_r.muldiv;
  assign illegal         = bundle_r.illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: directed plan steps plus random traffic
// checked against a behavioural decode/hold model. Honours RV32M_EN if defined.
module tb_pipelined_control_unit;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       instr_valid, stall, flush;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic       ready, valid_out, write_en, mem_write, mem_read, branch, jump, pc_select;
  logic       imm_select, jal_select, data_mem_select, muldiv, illegal, muldiv_busy;
  logic [2:0] imm_pick, alu_op;

  typedef struct packed {
    logic valid, we, mw, mr, br, jmp, pcs, imms, jals, dms;
    logic [2:0] pick;
    logic [2:0] alu;
    logic md, ill;
  } exp_t;

  exp_t m_b;
  int   m_left;
  int   total = 0;
  int   bad = 0;

  pipelined_control_unit #(.MULDIV_LATENCY(LAT), .ALU_OP_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .opcode(opcode),
    .func3(func3), .func7(func7), .stall(stall), .flush(flush), .ready(ready),
    .valid_out(valid_out), .write_en(write_en), .mem_write(mem_write), .mem_read(mem_read),
    .branch(branch), .jump(jump), .pc_select(pc_select), .imm_select(imm_select),
    .jal_select(jal_select), .data_mem_select(data_mem_select), .imm_pick(imm_pick),
    .alu_op(alu_op), .muldiv(muldiv), .illegal(illegal), .muldiv_busy(muldiv_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Reference decode written directly from the instruction-set rules
  function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    exp_t e;
    bit ok;
    e = '0;
    ok = 0;
    if (op == 7'b0110011) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.we = 1'b1;
`ifdef RV32M_EN
      if (f7 == 7'h01) begin ok = 1; e.md = 1'b1; e.alu = 3'd4; end
`endif
    end else if (op == 7'b0000011) begin
      ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      e.imms = 1; e.we = 1; e.mr = 1; e.dms = 1; e.alu = 3'd1;
    end else if (op == 7'b1100111) begin
      ok = (f3 == 3'd0);
      e.we = 1; e.jals = 1; e.imms = 1; e.jmp = 1; e.alu = 3'd2;
    end else if (op == 7'b0010011) begin
      if (f3 == 3'd1)      ok = (f7 == 7'h00);
      else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
      else                 ok = 1;
      e.we = 1; e.imms = 1; e.alu = 3'd3;
    end else if (op == 7'b0100011) begin
      ok = (f3 <= 3'd2);
      e.mw = 1; e.imms = 1; e.pick = 3'd1;
    end else if (op == 7'b0110111 || op == 7'b0010111) begin
      ok = 1;
      e.we = 1; e.imms = 1; e.pick = 3'd2; e.pcs = (op == 7'b0010111);
    end else if (op == 7'b1100011) begin
      ok = (f3 != 3'd2) && (f3 != 3'd3);
      e.br = 1; e.pcs = 1; e.imms = 1; e.pick = 3'd3;
    end else if (op == 7'b1101111) begin
      ok = 1;
      e.jmp = 1; e.jals = 1; e.pcs = 1; e.imms = 1; e.we = 1; e.pick = 3'd4;
    end
    if (!ok) begin e = '0; e.ill = 1; end
    e.valid = 1;
    return e;
  endfunction

  task automatic model_edge();
    if (flush) begin
      m_b = '0; m_left = 0;
    end else if (stall || m_left > 0) begin
      if (m_left > 0) m_left--;
    end else if (instr_valid) begin
      m_b = ref_decode(opcode, func3, func7);
      if (m_b.md) m_left = LAT - 1;
    end else begin
      m_b = '0;
    end
  endtask

  task automatic check_all(input string tag);
    exp_t o;
    o = '{valid_out, write_en, mem_write, mem_read, branch, jump, pc_select, imm_select,
          jal_select, data_mem_select, imm_pick, alu_op, muldiv, illegal};
    total++;
    assert (o === m_b) else begin
      bad++; $error("FAIL %s bundle observed=%h expected=%h", tag, o, m_b);
    end
    total++;
    assert (ready === (m_left == 0)) else begin
      bad++; $error("FAIL %s ready observed=%b expected=%b", tag, ready, (m_left == 0));
    end
    total++;
    assert (muldiv_busy === (m_left != 0)) else begin
      bad++; $error("FAIL %s busy observed=%b expected=%b", tag, muldiv_busy, (m_left != 0));
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic st, input logic fl);
    instr_valid = v; opcode = op; func3 = f3; func7 = f7; stall = st; flush = fl;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    m_b = '0; m_left = 0;
    check_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [6:0] ops [10];
    ops = '{7'b0110011, 7'b0000011, 7'b1100111, 7'b0010011, 7'b0100011,
            7'b0110111, 7'b0010111, 7'b1100011, 7'b1101111, 7'b0000000};
    m_b = '0; m_left = 0;
    reset_n = 1'b0;
    drive(1, 7'b0110011, 3'd0, 7'h00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");
    chk("reset_ready", {2'b00, ready}, 3'd1);
    @(negedge clk);
    reset_n = 1'b1;
    step("first_add");
    chk("add_we", {2'b00, write_en}, 3'd1);
    chk("add_valid", {2'b00, valid_out}, 3'd1);

    drive(1, 7'b0000011, 3'd2, 7'h00, 0, 0);
    step("lw");
    chk("lw_mem_read", {2'b00, mem_read}, 3'd1);
    chk("lw_dms", {2'b00, data_mem_select}, 3'd1);
    chk("lw_alu", alu_op, 3'd1);
    drive(1, 7'b0100011, 3'd2, 7'h00, 0, 0);
    step("sw");
    chk("sw_mem_write", {2'b00, mem_write}, 3'd1);
    chk("sw_pick", imm_pick, 3'd1);
    chk("sw_we", {2'b00, write_en}, 3'd0);

    drive(1, 7'b1101111, 3'd0, 7'h00, 0, 0);
    step("jal");
    for (int i = 0; i < 2; i++) begin
      drive(1, 7'b0010011, 3'd0, 7'h00, 1, 0);
      step("jal_stall");
      chk("stall_jump", {2'b00, jump}, 3'd1);
      chk("stall_pick", imm_pick, 3'd4);
    end
    drive(1, 7'b0010011, 3'd0, 7'h00, 0, 0);
    step("addi_after_stall");
    chk("addi_alu", alu_op, 3'd3);

`ifdef RV32M_EN
    drive(1, 7'b0110011, 3'd0, 7'h01, 0, 0);
    step("mul");
    for (int i = 0; i < LAT - 1; i++) begin
      chk("mul_md", {2'b00, muldiv}, 3'd1);
      chk("mul_ready", {2'b00, ready}, 3'd0);
      drive(1, 7'b0010011, 3'd0, 7'h00, 0, 0);
      step("mul_hold");
    end
    chk("mul_last_md", {2'b00, muldiv}, 3'd1);
    chk("mul_last_alu", alu_op, 3'd4);
    step("addi_after_mul");
    chk("addi_after_mul_alu", alu_op, 3'd3);
    drive(1, 7'b0110011, 3'd0, 7'h01, 0, 0);
    step("mul2");
    drive(1, 7'b0110011, 3'd0, 7'h00, 1, 1);
    step("mul_flush");
    chk("flush_valid", {2'b00, valid_out}, 3'd0);
    chk("flush_busy", {2'b00, muldiv_busy}, 3'd0);
    chk("flush_ready", {2'b00, ready}, 3'd1);
    drive(1, 7'b0110011, 3'd4, 7'h01, 0, 0);
    step("mul3");
    async_reset("reset_mid_mul");
    chk("reset_mid_mul_ready", {2'b00, ready}, 3'd1);
`else
    drive(1, 7'b0110011, 3'd0, 7'h01, 0, 0);
    step("mul_illegal");
    chk("mul_ill", {2'b00, illegal}, 3'd1);
    chk("mul_md_off", {2'b00, muldiv}, 3'd0);
`endif

    drive(1, 7'b1111111, 3'd0, 7'h00, 0, 0);
    step("ill_op");
    chk("ill_op_flag", {2'b00, illegal}, 3'd1);
    drive(1, 7'b0010011, 3'd1, 7'h20, 0, 0);
    step("ill_slli");
    chk("ill_slli_flag", {2'b00, illegal}, 3'd1);
    drive(0, 7'b0010011, 3'd0, 7'h00, 0, 0);
    step("bubble");

    for (int i = 0; i < 600; i++) begin
      logic [6:0] f7r;
      int sel;
      sel = $urandom_range(0, 3);
      f7r = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : 7'($urandom);
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)],
            3'($urandom_range(0, 7)), f7r,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0));
      step("random");
      if (i == 300) async_reset("random_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
